paddsb_seq: RTL and testbench



---
 rtl/paddsb_seq.sv | 139 +++++++++++++
 tb/tb_paddsb_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddsb_seq.sv
// Multi-cycle packed saturating sub-word adder: one shared LANE_W-bit
// saturating adder lane is stepped across all LANES lanes, one lane per cycle.
module paddsb_seq #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANE_W*LANES-1:0] A,
    input  logic [LANE_W*LANES-1:0] B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W*LANES-1:0] Sum,
    output logic [LANES-1:0]        sat,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; operands are taken only in IDLE, results are held in DONE until
    // out_ready, and valid never depends combinationally on ready.

    localparam int DW  = LANE_W * LANES;
    localparam int CW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MSB = LANE_W - 1;

    localparam logic [LANE_W-1:0] SAT_POS = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SAT_NEG = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]     a_q, b_q;
    logic [DW-1:0]     sum_q;
    logic [LANES-1:0]  sat_q;
    logic [CW-1:0]     cnt;

    logic [LANE_W-1:0] lane_a, lane_b, lane_s, lane_res;
    logic              lane_ovf;
    logic              last_lane;
    logic              accept;

    assign last_lane = (cnt == CW'(LANES - 1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_lane) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select the lane addressed by the counter from the captured operands.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int k = 0; k < LANES; k++) begin
            if (cnt == CW'(k)) begin
                lane_a = a_q[k*LANE_W +: LANE_W];
                lane_b = b_q[k*LANE_W +: LANE_W];
            end
        end
    end

    // Signed overflow only when both inputs share a sign the sum does not.
    always_comb begin
        lane_s   = lane_a + lane_b;
        lane_ovf = (lane_a[MSB] == lane_b[MSB]) && (lane_s[MSB] != lane_a[MSB]);
        lane_res = lane_s;
        if (lane_ovf) begin
            lane_res = lane_s[MSB] ? SAT_POS : SAT_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            sat_q <= '0;
            cnt   <= '0;
        end else begin
            if (state == IDLE) begin
                if (accept) begin
                    a_q   <= A;
                    b_q   <= B;
                    sum_q <= '0;
                    sat_q <= '0;
                    cnt   <= '0;
                end
            end else if (state == BUSY) begin
                for (int k = 0; k < LANES; k++) begin
                    if (cnt == CW'(k)) begin
                        sum_q[k*LANE_W +: LANE_W] <= lane_res;
                        sat_q[k]                  <= lane_ovf;
                    end
                end
                cnt <= last_lane ? '0 : cnt + CW'(1);
            end
        end
    end

    assign Sum       = sum_q;
    assign sat       = sat_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_paddsb_seq.sv
// Directed self-checking bench for paddsb_seq: latency, saturation patterns,
// backpressure, asynchronous mid-operation reset and back-to-back throughput.
module tb_paddsb_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic [3:0]  sat;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    paddsb_seq #(.LANE_W(4), .LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .sat       (sat),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one accept edge, then scramble A/B so any
    // dependence on the live inputs after accept would show up.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = 16'h0;
        B = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b state=%0d, required 1 0 0 0",
                     in_ready, out_valid, busy, dbg_state);
        end
        n_checks++;
        if (Sum !== 16'h0 || sat !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: Sum=%h sat=%b, required 0000 0000", Sum, sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        start_op(16'h1234, 16'h2121);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== (i == 4)) begin
                n_fail++;
                $display("FAIL normal_cycle%0d: in_ready=%b out_valid=%b, required 0 %b",
                         i, in_ready, out_valid, (i == 4));
            end
        end
        n_checks++;
        if (Sum !== 16'h3355 || sat !== 4'b0000) begin
            n_fail++;
            $display("FAIL normal_result: Sum=%h sat=%b, required 3355 0000", Sum, sat);
        end
        release_result();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_idle: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_pos_ovf();
        int cyc;
        start_op(16'h7777, 16'h1111);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || Sum !== 16'h7777 || sat !== 4'b1111) begin
            n_fail++;
            $display("FAIL pos_ovf: cycles=%0d Sum=%h sat=%b, required 4 7777 1111", cyc, Sum, sat);
        end
        release_result();
    endtask

    // out_ready held high throughout BUSY must not cut the operation short.
    task automatic test_neg_ovf();
        int cyc;
        @(negedge clk);
        out_ready = 1'b1;
        start_op(16'h8888, 16'h8888);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || Sum !== 16'h8888 || sat !== 4'b1111) begin
            n_fail++;
            $display("FAIL neg_ovf: cycles=%0d Sum=%h sat=%b, required 4 8888 1111", cyc, Sum, sat);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_ovf_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_mixed_backpressure();
        int cyc;
        start_op(16'h7831, 16'h1F21);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || Sum !== 16'h7852 || sat !== 4'b1100) begin
            n_fail++;
            $display("FAIL mixed: cycles=%0d Sum=%h sat=%b, required 4 7852 1100", cyc, Sum, sat);
        end
        // Offer a new operand pair while DONE; it must be ignored.
        in_valid = 1'b1;
        A = 16'h0101;
        B = 16'h0101;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (Sum !== 16'h7852 || sat !== 4'b1100 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: Sum=%h sat=%b in_ready=%b out_valid=%b, required 7852 1100 0 1",
                         i, Sum, sat, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        release_result();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || Sum !== 16'h7852 || sat !== 4'b1100) begin
            n_fail++;
            $display("FAIL backpressure_release: in_ready=%b busy=%b Sum=%h sat=%b, required 1 0 7852 1100",
                     in_ready, busy, Sum, sat);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(16'h1234, 16'h2121);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || Sum !== 16'h0 || sat !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b Sum=%h sat=%b, required 1 0 0 0000 0000",
                     in_ready, out_valid, busy, Sum, sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'h0001, 16'h0001);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || Sum !== 16'h0002 || sat !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_reset_op: cycles=%0d Sum=%h sat=%b, required 4 0002 0000", cyc, Sum, sat);
        end
        release_result();
    endtask

    // Constant in_valid/out_ready: accepts land every LANES+2 edges.
    task automatic test_back_to_back();
        int rdy_cnt;
        int vld_cnt;
        rdy_cnt = 0;
        vld_cnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        A = 16'h4321;
        B = 16'h1111;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) rdy_cnt++;
            if (out_valid) begin
                vld_cnt++;
                n_checks++;
                if (Sum !== 16'h5432 || sat !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL b2b_result: Sum=%h sat=%b, required 5432 0000", Sum, sat);
                end
            end
        end
        n_checks++;
        if (rdy_cnt !== 2 || vld_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_throughput: in_ready cycles=%0d out_valid cycles=%0d, required 2 2",
                     rdy_cnt, vld_cnt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_pos_ovf();
        test_neg_ovf();
        test_mixed_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
